// File: rtl/urisc_mem_pkg.sv
// Shared types and default sizes for the URISC data-memory controller.
// Optional feature macro used by the controller: URISC_MEM_PARITY_EN.
package urisc_mem_pkg;

   localparam int URISC_WIDTH = 16;
   localparam int URISC_DEPTH = 512;
   localparam int URISC_CW    = 16;

   // Controller states: zero-clearing the array, or serving the core.
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   // Classification of one bus cycle as seen by the controller.
   typedef enum logic [1:0] {
      ACC_NONE = 2'd0,
      ACC_RD   = 2'd1,
      ACC_WR   = 2'd2,
      ACC_BAD  = 2'd3
   } acc_e;

   // Read and write strobes only mean something when chip select is high;
   // both strobes at once is a protocol violation.
   function automatic acc_e decode_access(input logic cs, input logic rd, input logic wr);
      acc_e acc;
      if (!cs) begin
         acc = ACC_NONE;
      end else if (rd && wr) begin
         acc = ACC_BAD;
      end else if (rd) begin
         acc = ACC_RD;
      end else if (wr) begin
         acc = ACC_WR;
      end else begin
         acc = ACC_NONE;
      end
      return acc;
   endfunction

endpackage

// File: rtl/urisc_sram_1rw.sv
// Single-port synchronous storage array: one write or one read per cycle,
// read data captured in an output register that holds until the next read.
// With URISC_MEM_PARITY_EN a combinational parity-check of the addressed
// word is exported so the controller can flag it on the read edge.
module urisc_sram_1rw #(
   parameter int W     = 16,
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
`ifdef URISC_MEM_PARITY_EN
   ,output logic         rd_perr
`endif
);

   logic [W-1:0] mem [DEPTH];

   // Array write port; contents are initialised by the controller's clear sweep.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Registered read port; holds its value on non-read cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= {W{1'b0}};
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

`ifdef URISC_MEM_PARITY_EN
   // Stored words carry even parity, so any odd reduction means corruption.
   assign rd_perr = ^mem[addr];
`endif

endmodule

// File: rtl/urisc_data_mem_ctrl.sv
// Memory-side responder for the URISC core data bus.
// Zero-clears the array after reset or on request while Busy is high, then
// serves single-cycle writes and latency-1 reads, flags protocol misuse and
// counts accepted accesses with saturating counters.
// Optional feature macro: URISC_MEM_PARITY_EN (per-word even parity bit and
// sticky Err_parity output).
module urisc_data_mem_ctrl
   import urisc_mem_pkg::*;
#(
   parameter int WIDTH = URISC_WIDTH,
   parameter int DEPTH = URISC_DEPTH,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = URISC_CW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             CS,
   input  logic             Read,
   input  logic             Write,
   input  logic [AW-1:0]    Addr,
   input  logic [WIDTH-1:0] Data_in,
   input  logic             Clear,
   output logic [WIDTH-1:0] Data_out,
   output logic             Busy,
   output logic             Err_proto,
   output logic [CW-1:0]    Rd_cnt,
   output logic [CW-1:0]    Wr_cnt
`ifdef URISC_MEM_PARITY_EN
   ,output logic            Err_parity
`endif
);

`ifdef URISC_MEM_PARITY_EN
   localparam int MW = WIDTH + 1;
`else
   localparam int MW = WIDTH;
`endif

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

`ifdef URISC_MEM_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction
`endif

   state_e          state;
   state_e          next_state;
   logic [AW-1:0]   ptr;
   logic [AW-1:0]   ptr_next;
   acc_e            acc;
   logic            mem_we;
   logic            mem_re;
   logic [AW-1:0]   mem_addr;
   logic [MW-1:0]   mem_wdata;
   logic [MW-1:0]   mem_rdata;
   logic            proto_hit;
   logic            rd_ok;
   logic            wr_ok;

   // Next-state, array control and access qualification.
   always_comb begin
      acc        = decode_access(CS, Read, Write);
      next_state = state;
      ptr_next   = ptr;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = Addr;
      mem_wdata  = {MW{1'b0}};
      proto_hit  = 1'b0;
      rd_ok      = 1'b0;
      wr_ok      = 1'b0;
      case (state)
         CLEAR: begin
            // Sweep zeros (parity 0 included) and reject any core access.
            mem_we    = 1'b1;
            mem_addr  = ptr;
            ptr_next  = ptr + PTR_ONE;
            proto_hit = (acc != ACC_NONE);
            if (ptr == PTR_LAST) begin
               next_state = READY;
            end else begin
               next_state = CLEAR;
            end
         end
         READY: begin
            if (Clear) begin
               // Restart the sweep; an access in this cycle is dropped.
               next_state = CLEAR;
               ptr_next   = {AW{1'b0}};
               proto_hit  = (acc == ACC_BAD);
            end else begin
               case (acc)
                  ACC_WR: begin
                     mem_we = 1'b1;
                     wr_ok  = 1'b1;
`ifdef URISC_MEM_PARITY_EN
                     mem_wdata = {even_parity(Data_in), Data_in};
`else
                     mem_wdata = Data_in;
`endif
                  end
                  ACC_RD: begin
                     mem_re = 1'b1;
                     rd_ok  = 1'b1;
                  end
                  ACC_BAD: begin
                     proto_hit = 1'b1;
                  end
                  default: begin
                     proto_hit = 1'b0;
                  end
               endcase
            end
         end
         default: begin
            next_state = CLEAR;
            ptr_next   = {AW{1'b0}};
         end
      endcase
   end

   // State, clear pointer, Busy, sticky protocol flag and saturating counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= CLEAR;
         ptr       <= {AW{1'b0}};
         Busy      <= 1'b1;
         Err_proto <= 1'b0;
         Rd_cnt    <= {CW{1'b0}};
         Wr_cnt    <= {CW{1'b0}};
      end else begin
         state     <= next_state;
         ptr       <= ptr_next;
         Busy      <= (next_state == CLEAR);
         Err_proto <= Err_proto | proto_hit;
         if (rd_ok && (Rd_cnt != CNT_MAX)) begin
            Rd_cnt <= Rd_cnt + CNT_ONE;
         end
         if (wr_ok && (Wr_cnt != CNT_MAX)) begin
            Wr_cnt <= Wr_cnt + CNT_ONE;
         end
      end
   end

`ifdef URISC_MEM_PARITY_EN
   logic rd_perr;

   // Sticky parity flag, set on the same edge the faulty word reaches Data_out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Err_parity <= 1'b0;
      end else begin
         Err_parity <= Err_parity | (rd_ok & rd_perr);
      end
   end
`endif

   urisc_sram_1rw #(
      .W     (MW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sram (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
`ifdef URISC_MEM_PARITY_EN
      ,.rd_perr (rd_perr)
`endif
   );

   assign Data_out = mem_rdata[WIDTH-1:0];

endmodule

// File: tb/tb_urisc_data_mem_ctrl.sv
// Scoreboard bench for urisc_data_mem_ctrl: a behavioural model predicts the
// outputs after every clock edge, a separate monitor compares them.
module tb_urisc_data_mem_ctrl;

   localparam int WIDTH = 16;
   localparam int DEPTH = 512;
   localparam int AW    = 9;
   localparam int CW    = 4;
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             CS = 1'b0;
   logic             Read = 1'b0;
   logic             Write = 1'b0;
   logic [AW-1:0]    Addr = '0;
   logic [WIDTH-1:0] Data_in = '0;
   logic             Clear = 1'b0;
   logic [WIDTH-1:0] Data_out;
   logic             Busy;
   logic             Err_proto;
   logic [CW-1:0]    Rd_cnt;
   logic [CW-1:0]    Wr_cnt;
`ifdef URISC_MEM_PARITY_EN
   logic             Err_parity;
`endif

   urisc_data_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
      .clk(clk), .reset(reset), .CS(CS), .Read(Read), .Write(Write),
      .Addr(Addr), .Data_in(Data_in), .Clear(Clear), .Data_out(Data_out),
      .Busy(Busy), .Err_proto(Err_proto), .Rd_cnt(Rd_cnt), .Wr_cnt(Wr_cnt)
`ifdef URISC_MEM_PARITY_EN
      ,.Err_parity(Err_parity)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] dout;
      logic             busy;
      logic             ep;
      logic             pp;
      logic [CW-1:0]    rc;
      logic [CW-1:0]    wc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err = 0;

   // Behavioural reference model state
   logic [WIDTH-1:0] m_mem [DEPTH];
   bit               m_bad [DEPTH];
   int               m_clear_left;
   logic [WIDTH-1:0] m_dout;
   logic             m_ep, m_pp;
   logic [CW-1:0]    m_rc, m_wc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_mem[i]) begin m_mem[i] = '0; m_bad[i] = 1'b0; end
      m_clear_left = DEPTH;
      m_dout = '0; m_ep = 1'b0; m_pp = 1'b0; m_rc = '0; m_wc = '0;
   endtask

   // Predict the outputs after one edge with the given bus inputs.
   task automatic model_step(input bit cs, input bit rd, input bit wr,
                             input int a, input logic [WIDTH-1:0] d, input bit clr);
      exp_t e;
      if (m_clear_left > 0) begin
         if (cs && (rd || wr)) m_ep = 1'b1;
         m_clear_left--;
      end else if (clr) begin
         if (cs && rd && wr) m_ep = 1'b1;
         m_clear_left = DEPTH;
         foreach (m_mem[i]) begin m_mem[i] = '0; m_bad[i] = 1'b0; end
      end else if (cs && wr && !rd) begin
         m_mem[a] = d;
         m_bad[a] = 1'b0;
         if (m_wc != CMAX) m_wc++;
      end else if (cs && rd && !wr) begin
         m_dout = m_mem[a];
         if (m_bad[a]) m_pp = 1'b1;
         if (m_rc != CMAX) m_rc++;
      end else if (cs && rd && wr) begin
         m_ep = 1'b1;
      end
      e.dout = m_dout; e.busy = (m_clear_left > 0); e.ep = m_ep;
      e.pp = m_pp; e.rc = m_rc; e.wc = m_wc;
      exp_q.push_back(e);
   endtask

   // Drive one bus cycle; called at 1 time unit after a rising edge.
   task automatic bus(input bit cs, input bit rd, input bit wr,
                      input int a, input logic [WIDTH-1:0] d, input bit clr);
      CS = cs; Read = rd; Write = wr; Addr = AW'(a); Data_in = d; Clear = clr;
      model_step(cs, rd, wr, a, d, clr);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(1'b0, 1'($urandom), 1'($urandom), 0, '0, 1'b0);
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      CS = 1'b0; Read = 1'b0; Write = 1'b0; Clear = 1'b0;
      #1;
      model_reset();
      check("rst_dout", 32'(Data_out), 32'(m_dout));
      check("rst_busy", 32'(Busy), 32'd1);
      check("rst_errp", 32'(Err_proto), 32'd0);
      check("rst_rdcnt", 32'(Rd_cnt), 32'd0);
      check("rst_wrcnt", 32'(Wr_cnt), 32'd0);
`ifdef URISC_MEM_PARITY_EN
      check("rst_errpar", 32'(Err_parity), 32'd0);
`endif
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Monitor: after every edge out of reset, compare the DUT with the oldest prediction.
   always @(posedge clk) begin
      if (!reset) begin
         #2;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("data_out", 32'(Data_out), 32'(e.dout));
            check("busy", 32'(Busy), 32'(e.busy));
            check("err_proto", 32'(Err_proto), 32'(e.ep));
            check("rd_cnt", 32'(Rd_cnt), 32'(e.rc));
            check("wr_cnt", 32'(Wr_cnt), 32'(e.wc));
`ifdef URISC_MEM_PARITY_EN
            check("err_parity", 32'(Err_parity), 32'(e.pp));
`endif
         end
      end
   end

   initial begin
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // Clear sweep after reset, then read the top word.
      idle(DEPTH);
      bus(1'b1, 1'b1, 1'b0, 'h1FF, '0, 1'b0);
      idle(1);

      // Write then immediate read-back.
      bus(1'b1, 1'b0, 1'b1, 'h005, 16'hBEEF, 1'b0);
      bus(1'b1, 1'b1, 1'b0, 'h005, '0, 1'b0);
      idle(2);

      // Both strobes: protocol error, memory untouched.
      bus(1'b1, 1'b1, 1'b1, 'h005, 16'h1234, 1'b0);
      bus(1'b1, 1'b1, 1'b0, 'h005, '0, 1'b0);
      idle(1);

      // Clear pulse, read while busy is dropped, then the word reads back zero.
      bus(1'b1, 1'b0, 1'b1, 'h006, 16'h5A5A, 1'b0);
      bus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
      bus(1'b1, 1'b1, 1'b0, 'h005, '0, 1'b0);
      idle(DEPTH);
      bus(1'b1, 1'b1, 1'b0, 'h005, '0, 1'b0);
      idle(1);

      // Reset in the middle of a clear sweep.
      bus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
      idle(200);
      do_reset();
      idle(DEPTH - 1);
      bus(1'b1, 1'b1, 1'b0, 'h005, '0, 1'b0);
      idle(1);

`ifdef URISC_MEM_PARITY_EN
      // Corrupt one stored data bit and read it back.
      bus(1'b1, 1'b0, 1'b1, 'h010, 16'h00F0, 1'b0);
      dut.u_sram.mem[16][3] = ~dut.u_sram.mem[16][3];
      m_mem[16] = m_mem[16] ^ 16'h0008;
      m_bad[16] = 1'b1;
      bus(1'b1, 1'b1, 1'b0, 'h010, '0, 1'b0);
      idle(1);
`endif

      // Randomised traffic on a small address window, with rare clears.
      for (int i = 0; i < 600; i++) begin
         int op;
         int a;
         op = int'($urandom_range(0, 9));
         a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                          : int'($urandom_range(0, 15));
         if ($urandom_range(0, 249) == 0) begin
            bus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
         end else if (op < 4) begin
            bus(1'b1, 1'b0, 1'b1, a, WIDTH'($urandom), 1'b0);
         end else if (op < 8) begin
            bus(1'b1, 1'b1, 1'b0, a, '0, 1'b0);
         end else if (op == 8) begin
            bus(1'b1, 1'b1, 1'b1, a, WIDTH'($urandom), 1'b0);
         end else begin
            bus(1'b0, 1'($urandom), 1'($urandom), a, WIDTH'($urandom), 1'b0);
         end
      end

      idle(2);
      #3;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
